// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO registers.
//
// A MULT/MULTU/DIV/DIVU sampled on start runs through 32 shift-add or
// restoring shift-subtract steps on operand magnitudes. A final FIX cycle
// applies sign correction and writes HI/LO. MTHI/MTLO write HI/LO directly
// while the unit is idle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (priority over everything)
//   start        launch op on a/b (sampled only in IDLE)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         rs / rt operands
//   mthi, mtlo   write wdata to HI / LO (idle and no start only)
//   wdata        MTHI/MTLO data
//   busy         operation in progress (registered)
//   done         one-cycle pulse, new hi/lo valid this cycle
//   hi, lo       architectural HI / LO registers
//   dbg_state_o  current FSM state (0 IDLE, 1 RUN, 2 FIX)
//
// Handshake: start is a single-cycle request that is accepted only when
// busy=0. It is not queued. The result is valid in the cycle done=1, and
// hi/lo keep that result until the next FIX, MTHI/MTLO or reset.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;         // negate product / quotient
  logic        rneg_q, rneg_d;       // negate remainder
  logic        dvz_q, dvz_d;         // divisor was zero
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Operand magnitudes at launch
  logic        signed_op;
  logic [31:0] abs_a, abs_b;

  // Datapath step results
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [33:0] div_trial;
  logic [63:0] div_next;

  // Sign-corrected results
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    signed_op = ~op[0];
    abs_a     = (signed_op && a[31]) ? (~a + 32'd1) : a;
    abs_b     = (signed_op && b[31]) ? (~b + 32'd1) : b;

    // Shift-add: add multiplicand when the current multiplier LSB is set,
    // then shift the whole accumulator right (carry enters at bit 63).
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    mul_next = {mul_sum, acc_q[31:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the subtraction only if it did not go negative.
    div_shift = {acc_q[63:32], acc_q[31]};
    div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
    if (!div_trial[33]) begin
      div_next = {div_trial[31:0], acc_q[30:0], 1'b1};
    end else begin
      div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
    end

    prod_fix = neg_q  ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = neg_q  ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dvz_d    = dvz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = 5'd0;
          is_div_d = op[1];
          acc_d    = {32'd0, (op[1] ? abs_a : abs_b)};
          opnd_d   = op[1] ? abs_b : abs_a;
          neg_d    = signed_op & (a[31] ^ b[31]);
          rneg_d   = signed_op & op[1] & a[31];
          dvz_d    = op[1] & (b == 32'd0);
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          // With a zero divisor every trial succeeds, so the remainder ends
          // as |a|; sign correction restores the original a into HI.
          lo_d = dvz_q ? 32'hFFFF_FFFF : quo_fix;
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[31:0];
          hi_d = prod_fix[63:32];
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dvz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dvz_q    <= dvz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state_o(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b00: res = sx * sy;
      2'b01: res = ux * uy;
      default: begin
        if (y == 32'd0) begin
          res = {x, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          q = sx / sy;   // truncates toward zero, remainder takes dividend sign
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {32'(ux % uy), 32'(ux / uy)};
        end
      end
    endcase
    return res;
  endfunction

  // ---------------- driver ----------------
  // Issues one op, checks latency, busy length, hi/lo hold, result and that
  // no extra done/busy follows. inj>0 re-pulses start+mthi during RUN.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic with_mthi, input int inj);
    logic [31:0] h0, l0;
    logic [63:0] exp;
    int bc, dc;
    logic held, quiet;
    exp_q.push_back(model(o, av, bv));
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1; mthi = with_mthi; wdata = 32'hBAD0_BAD0;
    h0 = hi; l0 = lo;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;  // must not affect result
    bc = 0; dc = 0; held = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (inj != 0 && i == inj) begin
        start = 1'b1; mthi = 1'b1; wdata = 32'h0000_DEAD;
      end else if (inj != 0 && i == inj + 1) begin
        start = 1'b0; mthi = 1'b0;
      end
      if (busy) bc++;
      if (done) begin dc = i; break; end
      if (hi !== h0 || lo !== l0) held = 1'b0;
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0;
    exp = exp_q.pop_front();
    chk({nm, " done_cycle"}, 64'(dc), 64'd34);
    chk({nm, " busy_cycles"}, 64'(bc), 64'd33);
    chk({nm, " busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({nm, " hold"}, {63'd0, held}, 64'd1);
    chk({nm, " hilo"}, {hi, lo}, exp);
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk({nm, " quiet_after"}, {63'd0, quiet}, 64'd1);
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  o;
    logic [31:0] av, bv;
    logic [31:0] eh, el;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{"mult_m7x6",   2'b00, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vecs[2] = '{"div_m7d2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_dz",     2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[4] = '{"div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{"mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[6] = '{"div_7dm2",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[7] = '{"div_m7dz",    2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = 32'd0; b = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);

    // table-driven vectors (hand-computed expectations)
    foreach (vecs[i]) begin
      chk({vecs[i].nm, " table"}, model(vecs[i].o, vecs[i].av, vecs[i].bv), {vecs[i].eh, vecs[i].el});
      run_op(vecs[i].nm, vecs[i].o, vecs[i].av, vecs[i].bv, 1'b0, 0);
      chk({vecs[i].nm, " table_hilo"}, {hi, lo}, {vecs[i].eh, vecs[i].el});
    end

    // start + mthi re-issued during RUN are ignored
    run_op("divu_17_5_inj", 2'b11, 32'd17, 32'd5, 1'b0, 10);
    chk("divu_17_5_vals", {hi, lo}, {32'd2, 32'd3});

    // MTLO in IDLE; hi unchanged
    begin
      logic [31:0] h_prev;
      h_prev = hi;
      @(negedge clk); mtlo = 1'b1; wdata = 32'h0000_1234;
      @(negedge clk); mtlo = 1'b0;
      chk("mtlo", {hi, lo}, {h_prev, 32'h0000_1234});
      @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
      @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
      chk("mthi_mtlo", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    end

    // start wins over mthi in the same cycle
    run_op("mult_with_mthi", 2'b00, 32'h1234_5678, 32'hFEDC_BA98, 1'b1, 0);

    // reset mid-operation
    begin
      logic clean;
      @(negedge clk); op = 2'b00; a = 32'd5; b = 32'd7; start = 1'b1;
      @(negedge clk); start = 1'b0;       // cycle 1
      repeat (14) @(negedge clk);         // cycle 15
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;         // cycle 16
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      chk("rst_mid_done", {63'd0, done}, 64'd0);
      chk("rst_mid_hilo", {hi, lo}, 64'd0);
      clean = 1'b1;
      repeat (25) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) clean = 1'b0;
      end
      chk("rst_mid_no_result", {63'd0, clean}, 64'd1);
      run_op("multu_3x4", 2'b01, 32'd3, 32'd4, 1'b0, 0);
      chk("multu_3x4_vals", {hi, lo}, {32'd0, 32'd12});
    end

    // randomized ops against the model
    for (int k = 0; k < 24; k++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: ra = 32'($urandom_range(0, 50));
        default: ;
      endcase
      run_op($sformatf("rand%0d", k), ro, ra, rb, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
